// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencer for the KNN datapath (distance unit + neighbour list).
//
// On start, walks every test point t against every data point d, reading
// both operands from external point memories (one-cycle read latency), and
// presents (A, B, id) triples to the datapath with a valid/ready handshake.
// The neighbour list is cleared before each test point; once the last triple
// of a test point has drained through the datapath (LAT cycles), tp_done
// pulses with tp_idx. done pulses together with the final tp_done.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              job request, sampled only while idle
//   busy, done         job in progress / one-cycle job-complete pulse
//   tp_addr, dp_addr   test/data point memory addresses
//   rd_en              read strobe for both memories (rdata valid next cycle)
//   tp_rdata, dp_rdata memory read data
//   A, B, id, valid    registered triple to the datapath
//   ready              datapath accepts the triple
//   list_clr           one-cycle pulse clearing accumulator and list
//   tp_done, tp_idx    one-cycle pulse + index of the finished test point
module knn_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NBR_TESTP = 4,
    parameter int NBR_DATAP = 10,
    parameter int ID_W      = DATA_W / 4,
    parameter int LAT       = 2,
    // Address widths are floored at 1 so single-point configurations still
    // have a legal port width.
    parameter int TP_AW     = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1,
    parameter int DP_AW     = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [TP_AW-1:0]  tp_addr,
    output logic [DP_AW-1:0]  dp_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] tp_rdata,
    input  logic [DATA_W-1:0] dp_rdata,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [ID_W-1:0]   id,
    output logic              valid,
    input  logic              ready,
    output logic              list_clr,
    output logic              tp_done,
    output logic [TP_AW-1:0]  tp_idx
);

    localparam int LC_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]       state;
    logic [TP_AW-1:0] t;
    logic [DP_AW-1:0] d;
    logic [LC_W-1:0]  lcnt;

    logic hs, last_d, last_t, drain_end, next_rd;

    assign hs        = (state == S_ISSUE) && valid && ready;
    assign last_d    = (d == DP_AW'(NBR_DATAP - 1));
    assign last_t    = (t == TP_AW'(NBR_TESTP - 1));
    assign drain_end = (state == S_DRAIN) && (lcnt == LC_W'(LAT - 1));
    // A non-final handshake prefetches the next data point in the same cycle
    // so LOAD can capture it one cycle later.
    assign next_rd   = hs && !last_d;

    assign busy     = (state != S_IDLE);
    assign list_clr = (state == S_CLR);
    assign rd_en    = (state == S_CLR) || next_rd;
    assign tp_done  = drain_end;
    assign done     = drain_end && last_t;
    assign tp_idx   = t;
    assign tp_addr  = t;
    assign dp_addr  = next_rd ? d + DP_AW'(1) : d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            t     <= '0;
            d     <= '0;
            lcnt  <= '0;
            A     <= '0;
            B     <= '0;
            id    <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLR;
                        t     <= '0;
                        d     <= '0;
                    end
                end
                S_CLR: state <= S_LOAD;
                S_LOAD: begin
                    A     <= tp_rdata;
                    B     <= dp_rdata;
                    id    <= ID_W'(d);
                    valid <= 1'b1;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Triple is held untouched until the datapath takes it.
                    if (hs) begin
                        valid <= 1'b0;
                        if (!last_d) begin
                            d     <= d + DP_AW'(1);
                            state <= S_LOAD;
                        end else begin
                            lcnt  <= '0;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    lcnt <= lcnt + LC_W'(1);
                    if (lcnt == LC_W'(LAT - 1)) begin
                        if (last_t) begin
                            state <= S_IDLE;
                        end else begin
                            t     <= t + TP_AW'(1);
                            d     <= '0;
                            state <= S_CLR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_ctrl.sv
module tb_knn_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic        busy, done, rd_en, valid, list_clr, tp_done;
    logic [1:0]  tp_addr, tp_idx;
    logic [3:0]  dp_addr;
    logic [31:0] tp_rdata = '0, dp_rdata = '0, A, B;
    logic [7:0]  id;

    // Single-point configuration instance
    logic        e_rst, e_start, e_ready;
    logic        e_busy, e_done, e_rd_en, e_valid, e_list_clr, e_tp_done;
    logic [0:0]  e_tp_addr, e_tp_idx, e_dp_addr;
    logic [31:0] e_tp_rdata = '0, e_dp_rdata = '0, e_A, e_B;
    logic [7:0]  e_id;

    always #5 clk = ~clk;

    knn_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .tp_addr(tp_addr), .dp_addr(dp_addr), .rd_en(rd_en),
        .tp_rdata(tp_rdata), .dp_rdata(dp_rdata), .A(A), .B(B), .id(id),
        .valid(valid), .ready(ready), .list_clr(list_clr),
        .tp_done(tp_done), .tp_idx(tp_idx)
    );

    knn_ctrl #(.NBR_TESTP(1), .NBR_DATAP(1), .LAT(1)) u_edge (
        .clk(clk), .rst(e_rst), .start(e_start), .busy(e_busy), .done(e_done),
        .tp_addr(e_tp_addr), .dp_addr(e_dp_addr), .rd_en(e_rd_en),
        .tp_rdata(e_tp_rdata), .dp_rdata(e_dp_rdata), .A(e_A), .B(e_B), .id(e_id),
        .valid(e_valid), .ready(e_ready), .list_clr(e_list_clr),
        .tp_done(e_tp_done), .tp_idx(e_tp_idx)
    );

    // Point memories: tp[i] = 0x100+i, dp[j] = 0x200+j, one-cycle read.
    always @(posedge clk) begin
        if (rd_en) begin
            tp_rdata <= 32'h100 + 32'(tp_addr);
            dp_rdata <= 32'h200 + 32'(dp_addr);
        end
        if (e_rd_en) begin
            e_tp_rdata <= 32'h100 + 32'(e_tp_addr);
            e_dp_rdata <= 32'h200 + 32'(e_dp_addr);
        end
    end

    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [7:0] i; } trip_t;
    trip_t exp_q[$];
    int    tp_q[$];

    int nchk = 0, nerr = 0;
    int rel = 0, exp_done_cyc = 0, n_tp = 0, n_done = 0, e_rd_cnt = 0;
    bit job_on = 0, chk_idle = 0, vld_d = 0, rd_d1 = 0, rd_d2 = 0;
    logic [3:0] dpa_d1 = '0, dpa_d2 = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard for the main instance
    always @(negedge clk) begin
        if (job_on) begin
            rel++;
            check("busy_in_job", 32'(busy), 1);
        end
        if (chk_idle) begin
            check("busy_after_done", 32'(busy), 0);
            chk_idle = 0;
        end
        if (valid && ready) begin
            if (exp_q.size() == 0) check("unexpected_handshake", 32'(id), 32'hffff);
            else begin
                trip_t e;
                e = exp_q.pop_front();
                check("trip_A", A, e.a);
                check("trip_B", B, e.b);
                check("trip_id", 32'(id), 32'(e.i));
            end
        end
        if (valid && !vld_d) begin
            // Read issued two cycles ago (LOAD in between) must match this id.
            check("rd_before_load", 32'(rd_d2), 1);
            check("rd_addr_eq_id", 32'(dpa_d2), 32'(id));
            check("tp_addr_eq_t", 32'h100 + 32'(tp_addr), A);
        end
        if (tp_done) begin
            check("clr_vs_tpdone", 32'(list_clr), 0);
            if (tp_q.size() == 0) check("unexpected_tp_done", 32'(tp_idx), 32'hffff);
            else check("tp_idx", 32'(tp_idx), 32'(tp_q.pop_front()));
            n_tp++;
        end
        if (done) begin
            n_done++;
            check("done_cycle", rel, exp_done_cyc);
            chk_idle = 1;
            job_on = 0;
        end
        vld_d  = valid;
        rd_d2  = rd_d1;  rd_d1  = rd_en;
        dpa_d2 = dpa_d1; dpa_d1 = dp_addr;
    end

    always @(negedge clk) if (e_rd_en) e_rd_cnt++;

    // mode: 0 plain, 1 backpressure at t=1/id=5, 2 second start at cycle 10,
    // 3 reset at t=2/d=4.
    task automatic run_job(input int mode, input int exp_cyc);
        bit stalled = 0, aborted = 0;
        for (int t = 0; t < 4; t++) begin
            for (int d = 0; d < 10; d++)
                exp_q.push_back('{32'h100 + 32'(t), 32'h200 + 32'(d), 8'(d)});
            tp_q.push_back(t);
        end
        n_tp = 0; n_done = 0; exp_done_cyc = exp_cyc;
        start = 1;
        @(posedge clk); #1;
        start = 0; rel = 0; job_on = 1;
        for (int k = 0; k < 400 && n_done == 0 && !aborted; k++) begin
            @(posedge clk); #1;
            start = (mode == 2 && rel == 9);
            if (mode == 1 && !stalled && valid && id == 8'd5 && A == 32'h101) begin
                ready = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_A", A, 32'h101);
                    check("stall_B", B, 32'h205);
                    check("stall_id", 32'(id), 5);
                    check("stall_valid", 32'(valid), 1);
                    check("stall_rd_en", 32'(rd_en), 0);
                    @(posedge clk); #1;
                end
                ready = 1; stalled = 1;
            end
            if (mode == 3 && valid && id == 8'd4 && A == 32'h102) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                check("rst_busy", 32'(busy), 0);
                check("rst_valid", 32'(valid), 0);
                check("rst_ABid", A | B | 32'(id), 0);
                check("rst_addr", 32'(tp_addr) | 32'(dp_addr) | 32'(tp_idx), 0);
                check("rst_strobes", {28'd0, rd_en, list_clr, tp_done, done}, 0);
                exp_q.delete(); tp_q.delete(); job_on = 0; aborted = 1;
            end
        end
        start = 0;
        repeat (40) @(posedge clk);
        #1;
        if (aborted) begin
            check("abort_tp_done", n_tp, 2);
            check("abort_done", n_done, 0);
        end else begin
            check("done_count", n_done, 1);
            check("tp_done_count", n_tp, 4);
            check("trip_q_empty", exp_q.size(), 0);
        end
        job_on = 0;
    endtask

    initial begin
        rst = 1; start = 0; ready = 1;
        e_rst = 1; e_start = 0; e_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", 32'(busy), 0);
        check("init_valid", 32'(valid), 0);
        check("init_ABid", A | B | 32'(id), 0);
        check("init_addr", 32'(tp_addr) | 32'(dp_addr) | 32'(tp_idx), 0);
        check("init_strobes", {28'd0, rd_en, list_clr, tp_done, done}, 0);
        rst = 0; e_rst = 0;
        @(posedge clk); #1;

        run_job(0, 92);
        run_job(1, 95);
        run_job(2, 92);
        run_job(3, 0);
        run_job(0, 92);

        // NBR_TESTP=1, NBR_DATAP=1, LAT=1: CLR, LOAD, ISSUE, DRAIN
        e_rd_cnt = 0;
        e_start = 1;
        @(posedge clk); #1;
        e_start = 0;
        @(negedge clk);
        check("e_c1_clr", 32'(e_list_clr), 1);
        check("e_c1_rd", 32'(e_rd_en), 1);
        @(negedge clk);
        check("e_c2_valid", 32'(e_valid), 0);
        check("e_c2_busy", 32'(e_busy), 1);
        @(negedge clk);
        check("e_c3_valid", 32'(e_valid), 1);
        check("e_c3_A", e_A, 32'h100);
        check("e_c3_B", e_B, 32'h200);
        check("e_c3_done", 32'(e_done), 0);
        @(negedge clk);
        check("e_c4_tp_done", 32'(e_tp_done), 1);
        check("e_c4_done", 32'(e_done), 1);
        check("e_c4_tp_idx", 32'(e_tp_idx), 0);
        @(negedge clk);
        check("e_c5_busy", 32'(e_busy), 0);
        check("e_rd_count", e_rd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
- Sequencer for the KNN datapath (distance unit + neighbour list).
- On start, walks every test point against every data point, read from two external point memories.
- Presents each (test, data, id) triple to the datapath with a valid/ready handshake and clears the neighbour list before each test point.
- Flags each finished test point so software/DMA can collect its neighbour list; flags completion of the whole job.

Parameters:
- DATA_W, 32, point word width (A/B operands).
- NBR_TESTP, 4, number of test points per job.
- NBR_DATAP, 10, number of data points per test point.
- ID_W, DATA_W/4, width of data-point ID sent to the list.
- LAT, 2, datapath latency in cycles from an accepted triple to its list update; sets drain length (LAT>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job request, sampled only in IDLE.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse, job complete.
- tp_addr  out  $clog2(NBR_TESTP)  test-point memory address.
- dp_addr  out  $clog2(NBR_DATAP)  data-point memory address.
- rd_en  out  1  read strobe for both memories; rdata valid next cycle.
- tp_rdata  in  DATA_W  test-point memory read data.
- dp_rdata  in  DATA_W  data-point memory read data.
- A  out  DATA_W  test operand to distance unit (registered).
- B  out  DATA_W  data operand to distance unit (registered).
- id  out  ID_W  data-point index, zero-extended (registered).
- valid  out  1  A/B/id valid.
- ready  in  1  datapath accepts triple.
- list_clr  out  1  one-cycle pulse, clears distance accumulator and neighbour list.
- tp_done  out  1  one-cycle pulse, current test point's list final.
- tp_idx  out  $clog2(NBR_TESTP)  index of the finished test point; valid with tp_done.

Behaviour:
- Reset
  - Synchronous. Next edge: state IDLE; t=0, d=0, drain counter 0.
  - All outputs 0, including A/B/id/addresses.
  - rst mid-job abandons the job; no done or tp_done is emitted.
- Counters
  - t in 0..NBR_TESTP-1 and d in 0..NBR_DATAP-1; tp_addr=t, dp_addr=d.
  - Neither counter wraps past its maximum; the state machine exits first.
- IDLE
  - busy=0.
  - start=1 -> CLR; t=0, d=0.
- CLR (1 cycle)
  - list_clr=1, rd_en=1 with addresses (t, d=0).
  - -> LOAD.
- LOAD (1 cycle)
  - A<=tp_rdata, B<=dp_rdata, id<=d, valid<=1.
  - -> ISSUE.
- ISSUE
  - valid=1. A, B and id are held stable while ready=0 (no limit on stall length).
  - On valid&ready with d<NBR_DATAP-1: valid<=0, d<=d+1, rd_en=1 with dp_addr=d+1 in the same cycle, -> LOAD.
  - On valid&ready with d==NBR_DATAP-1: valid<=0, drain counter<=0, -> DRAIN.
- DRAIN (LAT cycles)
  - Counter increments each cycle. In the last cycle: tp_done=1, tp_idx=t.
  - If t==NBR_TESTP-1: done=1 in that same cycle, -> IDLE.
  - Otherwise: t<=t+1, d<=0, -> CLR.
- busy
  - 1 from the cycle after start is accepted through the cycle done is asserted; 0 afterwards.
- start while busy is ignored (no queueing).
- rd_en is asserted only in CLR and on a non-final ISSUE handshake; never in IDLE.
- list_clr and tp_done are never asserted in the same cycle.
- Timing with ready tied 1
  - Per test point: 1 + 2*NBR_DATAP + LAT cycles.
  - Job length: NBR_TESTP*(1+2*NBR_DATAP+LAT) cycles (defaults: 4*23 = 92).
  - done is asserted in the 92nd cycle after start is sampled.
- NBR_DATAP=1: CLR -> LOAD -> ISSUE -> DRAIN, with no intermediate rd_en.

Test Plan:
- Full job, defaults, ready=1; memories hold tp[i]=0x100+i, dp[j]=0x200+j -> 40 handshakes; for each t, id sequence 0..9 with A=0x100+t, B=0x200+id; list_clr before each group; tp_done with tp_idx 0,1,2,3; done in cycle 92; busy low in cycle 93.
- Backpressure: ready=0 for 3 cycles while id=5 is presented (t=1) -> A=0x101, B=0x205, id=5 held; no rd_en during the stall; done arrives in cycle 95.
- Start while busy: second start pulse at cycle 10 -> ignored; exactly one done; 4 tp_done pulses total.
- Reset mid-job: rst at t=2, d=4 -> next cycle all outputs 0 and busy=0; no tp_done for t=2; new start -> tp_idx restarts at 0.
- Edge parameters: NBR_TESTP=1, NBR_DATAP=1, LAT=1 -> start, then CLR, LOAD, ISSUE, DRAIN; tp_done=done in cycle 4; exactly one rd_en.
- Memory protocol check: every rd_en is followed one cycle later by a LOAD capture; assert dp_addr==id for each captured triple and tp_addr==t throughout.
